// File: rtl/wm_pkg.sv
// Shared washing-machine codes: phase and mode selects, timer state, duration scaling.
package wm_pkg;

  typedef enum logic [1:0] {
    PH_SOAK  = 2'd0,
    PH_WASH  = 2'd1,
    PH_RINSE = 2'd2,
    PH_SPIN  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    MD_QUICK     = 2'd0,
    MD_NORMAL    = 2'd1,
    MD_HEAVY     = 2'd2,
    MD_SPIN_ONLY = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    TS_IDLE  = 3'd0,
    TS_LOAD  = 3'd1,
    TS_RUN   = 3'd2,
    TS_PAUSE = 3'd3,
    TS_DONE  = 3'd4
  } tmr_state_e;

  // Mode scaling with saturation; spin-only runs at normal length.
  function automatic int unsigned scale_dur(input int unsigned d, input logic [1:0] mode,
                                            input int unsigned sat);
    int unsigned s;
    case (mode_e'(mode))
      MD_QUICK: s = d >> 1;
      MD_HEAVY: s = d + (d >> 1);
      default:  s = d;
    endcase
    return (s > sat) ? sat : s;
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; freezes when en=0.
module wm_tick_prescaler #(
  parameter  int TICK_DIV = 1000,
  localparam int PW       = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic          tick,
  output logic [PW-1:0] count
);

  assign tick = en && (count == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tick ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase-duration timer: loads a mode-scaled duration per phase and counts it down in seconds.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int          TICK_DIV = 1000,
  parameter int          CNT_W    = 12,
  parameter int unsigned SOAK_S   = 300,
  parameter int unsigned WASH_S   = 900,
  parameter int unsigned RINSE_S  = 600,
  parameter int unsigned SPIN_S   = 300
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_enable,
  input  logic [1:0]       phase_sel,
  input  logic [1:0]       mode_sel,
  input  logic             hold,
  output logic             timer_done,
  output logic             busy,
  output logic             paused,
  output logic [CNT_W-1:0] remaining_s
);

  localparam int unsigned SAT_S = (32'd1 << CNT_W) - 32'd1;
  localparam int          PW    = $clog2(TICK_DIV);

  tmr_state_e       state;
  logic [1:0]       phase_q;
  int unsigned      base_s;
  logic [CNT_W-1:0] ld_val;
  logic             phase_chg;
  logic             count_go;
  logic             presc_clr;
  logic             tick;
  logic [PW-1:0]    unused_presc_count;

  always_comb begin
    base_s = SOAK_S;
    case (phase_e'(phase_sel))
      PH_WASH:  base_s = WASH_S;
      PH_RINSE: base_s = RINSE_S;
      PH_SPIN:  base_s = SPIN_S;
      default:  base_s = SOAK_S;
    endcase
  end

  assign ld_val = CNT_W'(scale_dur(base_s, mode_sel, SAT_S));

  assign phase_chg = (state == TS_RUN || state == TS_PAUSE || state == TS_DONE) &&
                     (phase_sel != phase_q);

  // Resuming from PAUSE counts on the release edge, so a pause costs exactly its hold cycles.
  assign count_go  = timer_enable && !phase_chg && !hold &&
                     (state == TS_RUN || state == TS_PAUSE);
  assign presc_clr = !timer_enable || state == TS_IDLE || state == TS_LOAD;

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_go),
    .clr   (presc_clr),
    .tick  (tick),
    .count (unused_presc_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TS_IDLE;
      phase_q     <= PH_SOAK;
      remaining_s <= '0;
    end else if (!timer_enable) begin
      state       <= TS_IDLE;
      remaining_s <= '0;
    end else if (phase_chg) begin
      state <= TS_LOAD;
    end else begin
      case (state)
        TS_IDLE: state <= TS_LOAD;
        TS_LOAD: begin
          phase_q     <= phase_sel;
          remaining_s <= ld_val;
          state       <= (ld_val == '0) ? TS_DONE : TS_RUN;
        end
        TS_RUN, TS_PAUSE: begin
          if (hold) begin
            state <= TS_PAUSE;
          end else begin
            state <= TS_RUN;
            if (tick) begin
              if (remaining_s == CNT_W'(1)) begin
                remaining_s <= '0;
                state       <= TS_DONE;
              end else begin
                remaining_s <= remaining_s - 1'b1;
              end
            end
          end
        end
        TS_DONE: state <= TS_DONE;
        default: state <= TS_IDLE;
      endcase
    end
  end

  // Level outputs decoded from the state register only; a frozen FSM still sees done.
  assign timer_done = (state == TS_DONE);
  assign busy       = (state == TS_LOAD || state == TS_RUN || state == TS_PAUSE);
  assign paused     = (state == TS_PAUSE);

endmodule

// File: tb/tb_wm_phase_timer.sv
// Bench for wm_phase_timer: vector table, hand-built pause/reset sequences, random vs model.
module tb_wm_phase_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       timer_enable;
  logic [1:0] phase_sel;
  logic [1:0] mode_sel;
  logic       hold;
  logic       timer_done, busy, paused;
  logic [11:0] remaining_s;
  logic       d2_done, d2_busy, d2_paused;
  logic [2:0] d2_rem;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wm_phase_timer #(.TICK_DIV(TD), .CNT_W(12), .SOAK_S(3), .WASH_S(5), .RINSE_S(2), .SPIN_S(0)) dut (
    .clk(clk), .rst_n(rst_n), .timer_enable(timer_enable), .phase_sel(phase_sel),
    .mode_sel(mode_sel), .hold(hold), .timer_done(timer_done), .busy(busy),
    .paused(paused), .remaining_s(remaining_s));

  wm_phase_timer #(.TICK_DIV(TD), .CNT_W(3), .SOAK_S(3), .WASH_S(6), .RINSE_S(2), .SPIN_S(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .timer_enable(timer_enable), .phase_sel(phase_sel),
    .mode_sel(mode_sel), .hold(hold), .timer_done(d2_done), .busy(d2_busy),
    .paused(d2_paused), .remaining_s(d2_rem));

  function automatic logic [31:0] pk(input logic d, input logic b, input logic p, input int r);
    return (32'(d) << 30) | (32'(b) << 29) | (32'(p) << 28) | (32'(r) & 32'h0fff_ffff);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_on, m_load, m_paused;
  int m_ph, m_total, m_elapsed, m_rem;

  function automatic int ref_scale(input int ph, input int md);
    int base[4] = '{3, 5, 2, 0};
    int s;
    s = base[ph];
    if (md == 0)      s = s / 2;
    else if (md == 2) s = (s * 3) / 2;
    return (s > 4095) ? 4095 : s;
  endfunction

  task automatic model_reset();
    m_on = 0; m_load = 0; m_paused = 0; m_ph = 0; m_total = 0; m_elapsed = 0; m_rem = 0;
  endtask

  task automatic model_step(input bit en, input int ps, input int md, input bit h);
    if (!en) begin
      m_on = 0; m_load = 0; m_paused = 0; m_rem = 0;
    end else if (!m_on) begin
      m_on = 1; m_load = 1;
    end else if (m_load) begin
      m_load = 0; m_ph = ps; m_rem = ref_scale(ps, md);
      m_total = m_rem * TD; m_elapsed = 0; m_paused = 0;
    end else if (ps != m_ph) begin
      m_load = 1; m_paused = 0;
    end else if (m_elapsed < m_total) begin
      if (h) m_paused = 1;
      else begin
        m_paused = 0;
        m_elapsed++;
        m_rem = (m_total - m_elapsed + TD - 1) / TD;
      end
    end
  endtask

  function automatic logic [31:0] model_out();
    bit d;
    d = m_on && !m_load && (m_elapsed >= m_total);
    return pk(d, m_on && !d, m_on && !m_load && !d && m_paused, m_rem);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic en; logic [1:0] ph; logic [1:0] md; logic h; int n;
    logic d; logic b; logic p; int rem; int rem2;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input logic en, input int ph, input int md, input logic h, input int n,
                      input logic d, input logic b, input logic p, input int rem, input int rem2);
    vec_t v;
    v.en = en; v.ph = 2'(ph); v.md = 2'(md); v.h = h; v.n = n;
    v.d = d; v.b = b; v.p = p; v.rem = rem; v.rem2 = rem2;
    vt.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; timer_enable = 1'b0; phase_sel = 2'd0; mode_sel = 2'd1; hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    bit ok;
    do_reset();
    check("reset_state", pk(timer_done, busy, paused, int'(remaining_s)), pk(0, 0, 0, 0));

    //   en ph md h  n   d b p rem rem2
    addv(1, 0, 1, 0, 1,  0,1,0, 0, -1);   // LOAD
    addv(1, 0, 1, 0, 1,  0,1,0, 3, -1);   // RUN, soak normal
    addv(1, 0, 1, 0, 11, 0,1,0, 1, -1);
    addv(1, 0, 1, 0, 1,  1,0,0, 0, -1);   // done 12 cycles after RUN entry
    addv(1, 0, 1, 0, 5,  1,0,0, 0, -1);   // level held
    addv(1, 1, 1, 0, 1,  0,1,0, 0, -1);   // phase change -> LOAD
    addv(1, 1, 1, 0, 1,  0,1,0, 5, -1);
    addv(1, 2, 1, 0, 2,  0,1,0, 2, -1);
    addv(1, 1, 0, 0, 2,  0,1,0, 2,  3);   // wash quick
    addv(1, 2, 1, 0, 2,  0,1,0, 2, -1);
    addv(1, 1, 2, 0, 2,  0,1,0, 7,  7);   // wash heavy; dut2 saturates
    addv(1, 1, 0, 0, 3,  0,1,0, 7,  7);   // mode change ignored
    addv(1, 3, 1, 0, 1,  0,1,0, 7, -1);   // LOAD keeps old remaining
    addv(1, 3, 1, 0, 1,  1,0,0, 0, -1);   // zero duration
    addv(1, 3, 1, 1, 3,  1,0,0, 0, -1);   // hold ignored in DONE
    addv(1, 0, 1, 0, 2,  0,1,0, 3, -1);
    addv(1, 0, 1, 0, 5,  0,1,0, 2, -1);
    addv(0, 0, 1, 0, 1,  0,0,0, 0, -1);   // abort
    addv(1, 0, 1, 0, 2,  0,1,0, 3, -1);   // full reload
    addv(1, 0, 1, 1, 1,  0,1,1, 3, -1);   // pause
    addv(1, 1, 1, 1, 1,  0,1,0, 3, -1);   // phase change while paused
    addv(1, 1, 1, 1, 1,  0,1,0, 5, -1);   // LOAD ignores hold
    addv(1, 1, 1, 1, 1,  0,1,1, 5, -1);
    addv(0, 1, 1, 1, 1,  0,0,0, 0, -1);

    foreach (vt[i]) begin
      timer_enable = vt[i].en; phase_sel = vt[i].ph; mode_sel = vt[i].md; hold = vt[i].h;
      repeat (vt[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), pk(timer_done, busy, paused, int'(remaining_s)),
            pk(vt[i].d, vt[i].b, vt[i].p, vt[i].rem));
      if (vt[i].rem2 >= 0)
        check($sformatf("vec%0d_sat", i), pk(d2_done, d2_busy, d2_paused, int'(d2_rem)),
              pk(0, 1, 0, vt[i].rem2));
    end

    // Pause mid-second: done must slip by exactly the hold length.
    do_reset();
    timer_enable = 1'b1; phase_sel = 2'd0; mode_sel = 2'd1;
    repeat (2) @(negedge clk);
    repeat (5) @(negedge clk);
    check("pause_pre_rem", 32'(remaining_s), 32'd2);
    hold = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(paused && busy && !timer_done && remaining_s == 12'd2)) ok = 1'b0;
    end
    check("pause_frozen", 32'(ok), 32'd1);
    hold = 1'b0;
    cyc = 15;
    while (!timer_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("pause_done_cycle", 32'(cyc), 32'd22);

    // Asynchronous reset with remaining_s=2.
    do_reset();
    timer_enable = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_pre", pk(timer_done, busy, paused, int'(remaining_s)), pk(0, 1, 0, 2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", pk(timer_done, busy, paused, int'(remaining_s)), pk(0, 0, 0, 0));
    @(negedge clk);

    // Random stimulus against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      check("rand", pk(timer_done, busy, paused, int'(remaining_s)), model_out());
      timer_enable = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 3) phase_sel = 2'($urandom_range(0, 3));
      mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 8) hold = ~hold;
      @(posedge clk);
      model_step(timer_enable, int'(phase_sel), int'(mode_sel), hold);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
